mcu_seq_core: RTL

//  Parametrised successor of the memory compute unit: a DEPTH x DATA_W register file with an integrated ALU.

---
 rtl/mcu_seq_core_if.sv | 25 ++
 rtl/mcu_seq_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_seq_core_if.sv
// Request/response bus for mcu_seq_core: valid/ready request and registered result/done/err outputs.
interface mcu_seq_core_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op;
    logic [ADDR_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [ADDR_W-1:0] op2;
    logic [DATA_W-1:0] out;
    logic              op_err;
    logic              op_done;

    modport master (
        output op_valid, op, op0, op1, op2,
        input  op_ready, out, op_err, op_done
    );

    modport slave (
        input  op_valid, op, op0, op1, op2,
        output op_ready, out, op_err, op_done
    );
endinterface

// File: rtl/mcu_seq_core.sv
// Register file with integrated ALU; iterative mul/div/shift. Optional feature macro: MCU_SAT_EN
// (saturating ADD/SUB with op_err on saturation).
module mcu_seq_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    mcu_seq_core_if.slave  bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_READ  = 4'd7;
    localparam logic [3:0] OP_WRITE = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_ASR   = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_SHIFT} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state, w_state_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_out, w_out_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [DATA_W-1:0] r_opa, w_opa_nxt;
    logic [DATA_W-1:0] r_opb, w_opb_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_dest, w_dest_nxt;
    logic [3:0]        r_op, w_op_nxt;

    logic              w_wr, w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    logic              w_accept;
    logic [DATA_W-1:0] w_a, w_b;
    logic [DATA_W-1:0] w_mul_acc;
    logic [DATA_W:0]   w_rem_sh;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_sh_val;
    logic [CNT_W-1:0]  w_sh_k;

    assign w_accept = bus.op_valid & r_ready;
    assign w_a      = r_mem[bus.op0];
    assign w_b      = r_mem[bus.op1[ADDR_W-1:0]];

    // One shift-add step, one restoring-division step, one single-bit shift.
    assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;
    assign w_rem_sh  = {r_acc, r_opa[DATA_W-1]};
    assign w_qbit    = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_nxt = w_qbit ? DATA_W'(w_rem_sh - {1'b0, r_opb}) : w_rem_sh[DATA_W-1:0];
    assign w_quot    = {r_opa[DATA_W-2:0], w_qbit};
    assign w_sh_val  = (r_cnt != '0) ? w_shifted : r_opa;
    assign w_sh_k    = (w_b >= DATA_W'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(w_b);

`ifdef MCU_SAT_EN
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
`endif

    always_comb begin
        case (r_op)
            OP_SHL:  w_shifted = {r_opa[DATA_W-2:0], 1'b0};
            OP_SHR:  w_shifted = {1'b0, r_opa[DATA_W-1:1]};
            OP_ASR:  w_shifted = {r_opa[DATA_W-1], r_opa[DATA_W-1:1]};
            default: w_shifted = r_opa;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_dest_nxt  = r_dest;
        w_op_nxt    = r_op;
        w_wr        = 1'b0;
        w_waddr     = r_dest;
        w_wdata     = '0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dest_nxt = bus.op2;
                    w_op_nxt   = bus.op;
                    w_waddr    = bus.op2;
                    case (bus.op)
                        OP_ADD: begin
                            w_wr       = 1'b1;
                            w_done_nxt = 1'b1;
`ifdef MCU_SAT_EN
                            if (w_sum[DATA_W]) begin
                                w_wdata   = '1;
                                w_err_nxt = 1'b1;
                            end else begin
                                w_wdata   = w_sum[DATA_W-1:0];
                            end
`else
                            w_wdata    = w_a + w_b;
`endif
                            w_out_nxt  = w_wdata;
                        end
                        OP_SUB: begin
                            w_wr       = 1'b1;
                            w_done_nxt = 1'b1;
`ifdef MCU_SAT_EN
                            if (w_a < w_b) begin
                                w_wdata   = '0;
                                w_err_nxt = 1'b1;
                            end else begin
                                w_wdata   = w_a - w_b;
                            end
`else
                            w_wdata    = w_a - w_b;
`endif
                            w_out_nxt  = w_wdata;
                        end
                        OP_OR, OP_AND, OP_XOR: begin
                            w_wr       = 1'b1;
                            w_done_nxt = 1'b1;
                            if (bus.op == OP_OR)       w_wdata = w_a | w_b;
                            else if (bus.op == OP_AND) w_wdata = w_a & w_b;
                            else                       w_wdata = w_a ^ w_b;
                            w_out_nxt  = w_wdata;
                        end
                        OP_READ: begin
                            w_out_nxt  = w_a;
                            w_done_nxt = 1'b1;
                        end
                        OP_WRITE: begin
                            w_wr       = 1'b1;
                            w_waddr    = bus.op0;
                            w_wdata    = bus.op1;
                            w_done_nxt = 1'b1;
                        end
                        OP_MUL: begin
                            w_opa_nxt   = w_a;
                            w_opb_nxt   = w_b;
                            w_acc_nxt   = '0;
                            w_cnt_nxt   = CNT_W'(DATA_W);
                            w_state_nxt = S_MUL;
                        end
                        OP_DIV: begin
                            if (w_b == '0) begin
                                w_done_nxt = 1'b1;
                                w_err_nxt  = 1'b1;
                            end else begin
                                w_opa_nxt   = w_a;
                                w_opb_nxt   = w_b;
                                w_acc_nxt   = '0;
                                w_cnt_nxt   = CNT_W'(DATA_W);
                                w_state_nxt = S_DIV;
                            end
                        end
                        OP_SHL, OP_SHR, OP_ASR: begin
                            w_opa_nxt   = w_a;
                            w_cnt_nxt   = w_sh_k;
                            w_state_nxt = S_SHIFT;
                        end
                        default: begin
                            w_done_nxt = 1'b1;
                            w_err_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                w_acc_nxt = w_mul_acc;
                w_opa_nxt = {r_opa[DATA_W-2:0], 1'b0};
                w_opb_nxt = {1'b0, r_opb[DATA_W-1:1]};
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_wr        = 1'b1;
                    w_wdata     = w_mul_acc;
                    w_out_nxt   = w_mul_acc;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                w_acc_nxt = w_rem_nxt;
                w_opa_nxt = w_quot;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_wr        = 1'b1;
                    w_wdata     = w_quot;
                    w_out_nxt   = w_quot;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_opa_nxt = w_sh_val;
                // A zero shift count still spends one cycle before completing.
                if (r_cnt > CNT_W'(1)) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                    w_wr        = 1'b1;
                    w_wdata     = w_sh_val;
                    w_out_nxt   = w_sh_val;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // No write-back may slip through while reset is held.
    assign w_we = w_wr & ~reset;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dest  <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dest  <= w_dest_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign bus.op_ready = r_ready;
    assign bus.out      = r_out;
    assign bus.op_done  = r_done;
    assign bus.op_err   = r_err;
endmodule
